// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared state encoding, constants and sizing helper for pipe_ctrl
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        CTRL_IDLE  = 2'd0,
        CTRL_FLUSH = 2'd1,
        CTRL_HOLD  = 2'd2
    } ctrl_state_e;

    localparam logic [31:0] ZERO_WORD = 32'h0000_0000;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/pipe_ctrl_sat_cnt.sv
// rtl/pipe_ctrl_sat_cnt.sv - 32-bit saturating event counter with enable and synchronous load
module pipe_ctrl_sat_cnt (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en_i,
    input  logic        load_i,
    input  logic [31:0] load_val_i,
    output logic [31:0] cnt_o
);

    logic [31:0] cnt_q;
    logic [31:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (en_i && (cnt_q != 32'hFFFF_FFFF)) begin
            cnt_d = cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= 32'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - jump/hold pipeline controller; PIPE_CTRL_STATS_EN adds jump/stall counters
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int FLUSH_CYCLES = 1,
    parameter int HOLD_CYCLES  = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        jump_en_i,
    input  logic [31:0] jump_addr_i,
    input  logic        hold_flag_i,
    input  logic        hold_req_i,
    output logic        pc_jump_en_o,
    output logic [31:0] pc_jump_addr_o,
    output logic        pc_hold_o,
    output logic        if_id_hold_o,
    output logic        flush_if_id_o,
    output logic        flush_id_ex_o
`ifdef PIPE_CTRL_STATS_EN
    ,
    output logic [31:0] stat_jump_cnt_o,
    output logic [31:0] stat_stall_cnt_o
`endif
);

    localparam int CW = $clog2(max2(FLUSH_CYCLES, HOLD_CYCLES) + 1);
    // The IDLE cycle that takes the event is the first of the burst, hence -2.
    localparam logic [CW-1:0] FLUSH_LOAD = CW'((FLUSH_CYCLES > 1) ? FLUSH_CYCLES - 2 : 0);
    localparam logic [CW-1:0] HOLD_LOAD  = CW'((HOLD_CYCLES > 1) ? HOLD_CYCLES - 2 : 0);

    ctrl_state_e   state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            CTRL_IDLE: begin
                if (jump_en_i) begin
                    if (FLUSH_CYCLES > 1) begin
                        state_d = CTRL_FLUSH;
                        cnt_d   = FLUSH_LOAD;
                    end
                end else if (hold_flag_i) begin
                    if (HOLD_CYCLES > 1) begin
                        state_d = CTRL_HOLD;
                        cnt_d   = HOLD_LOAD;
                    end
                end
            end
            CTRL_FLUSH, CTRL_HOLD: begin
                if (cnt_q == '0) begin
                    state_d = CTRL_IDLE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: begin
                state_d = CTRL_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= CTRL_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Outputs are combinational for zero-latency redirect; reset gates them off.
    always_comb begin
        pc_jump_en_o   = 1'b0;
        pc_jump_addr_o = ZERO_WORD;
        pc_hold_o      = 1'b0;
        if_id_hold_o   = 1'b0;
        flush_if_id_o  = 1'b0;
        flush_id_ex_o  = 1'b0;
        if (rst) begin
            case (state_q)
                CTRL_IDLE: begin
                    if (jump_en_i) begin
                        pc_jump_en_o   = 1'b1;
                        pc_jump_addr_o = jump_addr_i;
                        flush_if_id_o  = 1'b1;
                        flush_id_ex_o  = 1'b1;
                    end else if (hold_flag_i || hold_req_i) begin
                        pc_hold_o     = 1'b1;
                        if_id_hold_o  = 1'b1;
                        flush_id_ex_o = 1'b1;
                    end
                end
                CTRL_FLUSH: begin
                    flush_if_id_o = 1'b1;
                    flush_id_ex_o = 1'b1;
                end
                CTRL_HOLD: begin
                    pc_hold_o     = 1'b1;
                    if_id_hold_o  = 1'b1;
                    flush_id_ex_o = 1'b1;
                end
                default: ;
            endcase
        end
    end

`ifdef PIPE_CTRL_STATS_EN
    pipe_ctrl_sat_cnt u_jump_cnt (
        .clk        (clk),
        .rst_n      (rst),
        .en_i       (pc_jump_en_o),
        .load_i     (1'b0),
        .load_val_i (ZERO_WORD),
        .cnt_o      (stat_jump_cnt_o)
    );

    pipe_ctrl_sat_cnt u_stall_cnt (
        .clk        (clk),
        .rst_n      (rst),
        .en_i       (pc_hold_o),
        .load_i     (1'b0),
        .load_val_i (ZERO_WORD),
        .cnt_o      (stat_stall_cnt_o)
    );
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb/tb_pipe_ctrl.sv - scoreboard bench for pipe_ctrl (default and FLUSH=3/HOLD=4 builds) and its counter
module tb_pipe_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        jump_en = 1'b0;
    logic [31:0] jump_addr = 32'h0;
    logic        hold_flag = 1'b0;
    logic        hold_req = 1'b0;

    logic        a_pje, a_ph, a_ih, a_fi, a_fe;
    logic [31:0] a_addr;
    logic        b_pje, b_ph, b_ih, b_fi, b_fe;
    logic [31:0] b_addr;
`ifdef PIPE_CTRL_STATS_EN
    logic [31:0] a_sj, a_ss, b_sj, b_ss;
`endif

    logic        sat_en = 1'b0;
    logic        sat_load = 1'b0;
    logic [31:0] sat_val = 32'h0;
    logic [31:0] sat_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [4:0] F_ZERO  = 5'b00000;
    localparam logic [4:0] F_JUMP  = 5'b10011;
    localparam logic [4:0] F_HOLD  = 5'b01101;
    localparam logic [4:0] F_FLUSH = 5'b00011;

    typedef struct {
        bit          dut;
        logic [4:0]  flags;
        logic [31:0] addr;
        string       tag;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    pipe_ctrl dut_a (
        .clk(clk), .rst(rst), .jump_en_i(jump_en), .jump_addr_i(jump_addr),
        .hold_flag_i(hold_flag), .hold_req_i(hold_req),
        .pc_jump_en_o(a_pje), .pc_jump_addr_o(a_addr), .pc_hold_o(a_ph),
        .if_id_hold_o(a_ih), .flush_if_id_o(a_fi), .flush_id_ex_o(a_fe)
`ifdef PIPE_CTRL_STATS_EN
        , .stat_jump_cnt_o(a_sj), .stat_stall_cnt_o(a_ss)
`endif
    );

    pipe_ctrl #(.FLUSH_CYCLES(3), .HOLD_CYCLES(4)) dut_b (
        .clk(clk), .rst(rst), .jump_en_i(jump_en), .jump_addr_i(jump_addr),
        .hold_flag_i(hold_flag), .hold_req_i(hold_req),
        .pc_jump_en_o(b_pje), .pc_jump_addr_o(b_addr), .pc_hold_o(b_ph),
        .if_id_hold_o(b_ih), .flush_if_id_o(b_fi), .flush_id_ex_o(b_fe)
`ifdef PIPE_CTRL_STATS_EN
        , .stat_jump_cnt_o(b_sj), .stat_stall_cnt_o(b_ss)
`endif
    );

    pipe_ctrl_sat_cnt u_sat (
        .clk(clk), .rst_n(rst), .en_i(sat_en), .load_i(sat_load),
        .load_val_i(sat_val), .cnt_o(sat_cnt)
    );

    wire [4:0] a_flags = {a_pje, a_ph, a_ih, a_fi, a_fe};
    wire [4:0] b_flags = {b_pje, b_ph, b_ih, b_fi, b_fe};

    // Scoreboard consumer: outputs are combinational, so each entry is due in the cycle it was pushed.
    always @(negedge clk) begin
        exp_t        e;
        logic [4:0]  got_f;
        logic [31:0] got_a;
        #2;
        if (sb.size() > 0) begin
            e     = sb.pop_front();
            got_f = e.dut ? b_flags : a_flags;
            got_a = e.dut ? b_addr : a_addr;
            n_checks++;
            if (got_f !== e.flags || got_a !== e.addr) begin
                n_fail++;
                $display("FAIL %s: flags=%b addr=%h, expected flags=%b addr=%h",
                         e.tag, got_f, got_a, e.flags, e.addr);
            end
        end
        n_checks++;
        if ((a_fi && a_ih) || (b_fi && b_ih)) begin
            n_fail++;
            $display("FAIL flush_vs_hold_exclusive: a=%b%b b=%b%b, expected never both 1",
                     a_fi, a_ih, b_fi, b_ih);
        end
    end

    task automatic cyc(input logic j, input logic [31:0] a, input logic hf, input logic hr,
                       input bit dut, input logic [4:0] fl, input logic [31:0] ea,
                       input string tag);
        @(negedge clk);
        jump_en   = j;
        jump_addr = a;
        hold_flag = hf;
        hold_req  = hr;
        sb.push_back('{dut, fl, ea, tag});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            jump_en = 1'b0; jump_addr = 32'h0; hold_flag = 1'b0; hold_req = 1'b0;
        end
    endtask

    task automatic test_reset();
        jump_en = 1'b1; jump_addr = 32'hDEAD_BEEF; hold_req = 1'b1; hold_flag = 1'b1;
        repeat (3) @(negedge clk);
        #2;
        n_checks++;
        if (a_flags !== F_ZERO || a_addr !== 32'h0 || b_flags !== F_ZERO || b_addr !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: a=%b/%h b=%b/%h, expected all 0", a_flags, a_addr, b_flags, b_addr);
        end
        n_checks++;
        if (sat_cnt !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_sat_cnt: got %h, expected 0", sat_cnt);
        end
        @(negedge clk);
        rst = 1'b1;
        jump_en = 1'b0; jump_addr = 32'h0; hold_req = 1'b0; hold_flag = 1'b0;
        idle(2);
    endtask

    task automatic test_single_jump();
        cyc(1'b1, 32'h0000_0100, 1'b0, 1'b0, 1'b0, F_JUMP, 32'h100, "jump_default");
        cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, F_ZERO, 32'h0, "after_jump_default");
        idle(6);
    endtask

    task automatic test_flush_ignores_hold();
        cyc(1'b1, 32'h40, 1'b0, 1'b0, 1'b1, F_JUMP, 32'h40, "flush3_c0");
        cyc(1'b0, 32'h0, 1'b1, 1'b0, 1'b1, F_FLUSH, 32'h0, "flush3_c1");
        cyc(1'b1, 32'h80, 1'b1, 1'b1, 1'b1, F_FLUSH, 32'h0, "flush3_c2");
        cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, F_ZERO, 32'h0, "flush3_done");
        idle(6);
    endtask

    task automatic test_hold_burst();
        for (int i = 0; i < 6; i++) cyc(1'b0, 32'h0, 1'b1, 1'b0, 1'b1, F_HOLD, 32'h0, $sformatf("hold4_c%0d", i));
        cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, F_HOLD, 32'h0, "hold4_c6");
        cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, F_HOLD, 32'h0, "hold4_c7");
        cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, F_ZERO, 32'h0, "hold4_done");
        idle(6);
    endtask

    task automatic test_hold_req();
        cyc(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, F_HOLD, 32'h0, "hold_req_c0");
        cyc(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, F_HOLD, 32'h0, "hold_req_c1");
        cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, F_ZERO, 32'h0, "hold_req_release");
        cyc(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, F_HOLD, 32'h0, "hold_req_default");
        cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, F_ZERO, 32'h0, "hold_req_default_release");
        idle(6);
    endtask

    task automatic test_jump_beats_hold();
        cyc(1'b1, 32'h200, 1'b1, 1'b0, 1'b0, F_JUMP, 32'h200, "jump_and_hold");
        cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, F_ZERO, 32'h0, "jump_and_hold_after");
        idle(6);
    endtask

    task automatic test_reset_in_hold();
        cyc(1'b0, 32'h0, 1'b1, 1'b0, 1'b1, F_HOLD, 32'h0, "rst_hold_c0");
        cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, F_HOLD, 32'h0, "rst_hold_c1");
        #3;
        rst = 1'b0;
        #1;
        n_checks++;
        if (b_flags !== F_ZERO || b_addr !== 32'h0) begin
            n_fail++;
            $display("FAIL async_reset_in_hold: flags=%b addr=%h, expected 0", b_flags, b_addr);
        end
        @(negedge clk);
        rst = 1'b1;
        jump_en = 1'b1; jump_addr = 32'h0000_0300;
        sb.push_back('{1'b1, F_JUMP, 32'h300, "jump_after_reset"});
        cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, F_FLUSH, 32'h0, "jump_after_reset_f1");
        cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, F_FLUSH, 32'h0, "jump_after_reset_f2");
        cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, F_ZERO, 32'h0, "jump_after_reset_done");
        idle(6);
    endtask

    task automatic test_sat_cnt();
        @(negedge clk); sat_en = 1'b1;
        @(negedge clk);
        @(negedge clk); sat_en = 1'b0;
        #2;
        n_checks++;
        if (sat_cnt !== 32'd2) begin
            n_fail++;
            $display("FAIL sat_cnt_count: got %h, expected 2", sat_cnt);
        end
        @(negedge clk); sat_load = 1'b1; sat_val = 32'hFFFF_FFFE;
        @(negedge clk); sat_load = 1'b0; sat_en = 1'b1;
        @(negedge clk);
        #2;
        n_checks++;
        if (sat_cnt !== 32'hFFFF_FFFF) begin
            n_fail++;
            $display("FAIL sat_cnt_reach_max: got %h, expected ffffffff", sat_cnt);
        end
        @(negedge clk);
        @(negedge clk); sat_en = 1'b0;
        #2;
        n_checks++;
        if (sat_cnt !== 32'hFFFF_FFFF) begin
            n_fail++;
            $display("FAIL sat_cnt_saturate: got %h, expected ffffffff", sat_cnt);
        end
    endtask

`ifdef PIPE_CTRL_STATS_EN
    task automatic test_stats();
        @(negedge clk); rst = 1'b0;
        @(negedge clk); rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cyc(1'b1, 32'h1000 + 32'(k * 4), 1'b0, 1'b0, 1'b1, F_JUMP, 32'h1000 + 32'(k * 4), "stats_jump");
            idle(4);
        end
        cyc(1'b0, 32'h0, 1'b1, 1'b0, 1'b1, F_HOLD, 32'h0, "stats_hold");
        idle(6);
        #2;
        n_checks++;
        if (b_sj !== 32'd3 || b_ss !== 32'd4) begin
            n_fail++;
            $display("FAIL stats_flush3_hold4: jump=%0d stall=%0d, expected 3 and 4", b_sj, b_ss);
        end
        n_checks++;
        if (a_sj !== 32'd3 || a_ss !== 32'd1) begin
            n_fail++;
            $display("FAIL stats_default: jump=%0d stall=%0d, expected 3 and 1", a_sj, a_ss);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single_jump();
        test_flush_ignores_hold();
        test_hold_burst();
        test_hold_req();
        test_jump_beats_hold();
        test_reset_in_hold();
        test_sat_cnt();
`ifdef PIPE_CTRL_STATS_EN
        test_stats();
`endif
        idle(2);
        #3;
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drained: %0d entries left, expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time budget, expected completion");
        $fatal(1);
    end

endmodule
